// File: rtl/gray_ise_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_ise_pkg : opcodes, FSM encoding and gray->RGB565 expansion      |
// | Revision     : 1.0                                                   |
// +----------------------------------------------------------------------+
package gray_ise_pkg;

    localparam logic [1:0] OP_LOAD   = 2'd0;
    localparam logic [1:0] OP_FETCH  = 2'd1;
    localparam logic [1:0] OP_STATUS = 2'd2;
    localparam logic [1:0] OP_RSVD   = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CONV0 = 2'd1,
        ST_CONV1 = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // MSB replication keeps 0x00 -> black and 0xFF -> full white exactly.
    function automatic logic [15:0] expand_gray(input logic [7:0] g);
        return {g[7:3], g[7:2], g[7:3]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/gray8_to_rgb565.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray8_to_rgb565 : combinational 8-bit gray to RGB565 expander        |
// | Revision        : 1.0                                                |
// +----------------------------------------------------------------------+
module gray8_to_rgb565
    import gray_ise_pkg::*;
(
    input  logic [7:0]  i_gray,
    output logic [15:0] o_rgb565
);

    assign o_rgb565 = expand_gray(i_gray);

endmodule
`default_nettype wire

// File: rtl/gray_to_rgb565_ise.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | gray_to_rgb565_ise : CI that buffers four gray pixels and returns    |
// |                      two RGB565 pixels per FETCH                     |
// | Revision           : 1.0                                             |
// +----------------------------------------------------------------------+
module gray_to_rgb565_ise
    import gray_ise_pkg::*;
#(
    parameter logic [7:0] customId = 8'h00
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  iseId,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    state_t      state_q,   state_d;
    logic [31:0] pix_buf_q, pix_buf_d;
    logic [2:0]  count_q,   count_d;
    logic        err_q,     err_d;
    logic [15:0] pix0_q,    pix0_d;
    logic        done_q,    done_d;
    logic [31:0] result_q,  result_d;

    logic [1:0]  opcode;
    logic        accept;
    logic [1:0]  byte_sel;
    logic [7:0]  gray_byte;
    logic [15:0] pix_rgb;
    logic        unused_opcode_bits;

    assign opcode             = valueB[1:0];
    assign unused_opcode_bits = ^valueB[31:2];
    assign accept = start && (iseId == customId) &&
                    ((state_q == ST_IDLE) || (state_q == ST_RESP));

    // Read pointer is 4 - count: byte 0 with four left, byte 2 with two left.
    assign byte_sel  = {~count_q[2], (state_q == ST_CONV1)};
    assign gray_byte = pix_buf_q[byte_sel*8 +: 8];

    gray8_to_rgb565 u_conv (
        .i_gray   (gray_byte),
        .o_rgb565 (pix_rgb)
    );

    always_comb begin
        state_d   = state_q;
        pix_buf_d = pix_buf_q;
        count_d   = count_q;
        err_d     = err_q;
        pix0_d    = pix0_q;
        done_d    = 1'b0;
        result_d  = 32'h0;

        case (state_q)
            ST_CONV0: begin
                pix0_d  = pix_rgb;
                state_d = ST_CONV1;
            end
            ST_CONV1: begin
                result_d = {pix_rgb, pix0_q};
                done_d   = 1'b1;
                count_d  = count_q - 3'd2;
                state_d  = ST_RESP;
            end
            ST_RESP:  state_d = ST_IDLE;
            default:  ;
        endcase

        // Acceptance only happens in IDLE/RESP, so it never collides with
        // the conversion steps above.
        if (accept) begin
            state_d = ST_RESP;
            done_d  = 1'b1;
            case (opcode)
                OP_LOAD: begin
                    pix_buf_d = valueA;
                    count_d   = 3'd4;
                end
                OP_FETCH: begin
                    if (count_q >= 3'd2) begin
                        state_d = ST_CONV0;
                        done_d  = 1'b0;
                    end else begin
                        err_d = 1'b1;
                    end
                end
                OP_STATUS: begin
                    result_d = {23'b0, err_q, 5'b0, count_q};
                    err_d    = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            pix_buf_q <= 32'h0;
            count_q   <= 3'd0;
            err_q     <= 1'b0;
            pix0_q    <= 16'h0;
            done_q    <= 1'b0;
            result_q  <= 32'h0;
        end else begin
            state_q   <= state_d;
            pix_buf_q <= pix_buf_d;
            count_q   <= count_d;
            err_q     <= err_d;
            pix0_q    <= pix0_d;
            done_q    <= done_d;
            result_q  <= result_d;
        end
    end

    assign done   = done_q;
    assign result = result_q;

endmodule
`default_nettype wire
